fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port RAM. It turns a push/pop handshake into the RAM's `we`/`w_addr` and `re`/`r_addr` controls, and tracks occupancy with full/empty/count status. Write data goes straight to the RAM `din`; read data is taken from the RAM `dout`, qualified by `rd_valid`. Together, controller and RAM form a 16-entry, 8-bit FIFO.

## Interface
Parameters:
- `ADDR_W`, default 4, RAM address width; depth `DEPTH = 2**ADDR_W` (derived, not overridable)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `push`  in  1  write request; data is presented on the RAM `din` in the same cycle
- `pop`  in  1  read request
- `we`  out  1  RAM write enable: `push & ~full & ~rst` (combinational)
- `w_addr`  out  `ADDR_W`  RAM write address: low bits of the write pointer (registered)
- `re`  out  1  RAM read enable: `pop & ~empty & ~rst` (combinational)
- `r_addr`  out  `ADDR_W`  RAM read address: low bits of the read pointer (registered)
- `rd_valid`  out  1  RAM `dout` holds a popped word this cycle (registered)
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `count`  out  `ADDR_W+1`  occupancy, 0..DEPTH
- `ovf`  out  1  sticky overflow flag; present only with `FIFO_CTRL_ERR_EN`
- `udf`  out  1  sticky underflow flag; present only with `FIFO_CTRL_ERR_EN`

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` are each `ADDR_W+1` bits; the MSB is the wrap bit.
  - `count = wr_ptr - rd_ptr`, modulo 2^(`ADDR_W+1`).
  - `full` when the MSBs differ and the low bits are equal; `empty` when the pointers are equal.
- Push acceptance: a push is accepted iff `~full`. Acceptance asserts `we`; the RAM writes `din` at `w_addr` on the edge, and `wr_ptr` increments on that edge.
- Pop acceptance: a pop is accepted iff `~empty`. Acceptance asserts `re`; the RAM loads `dout` from `r_addr` on the edge, and `rd_ptr` increments on that edge.
- `full` and `empty` are evaluated on the current-cycle state. A pop in the same cycle does not free space for a push; a push in the same cycle does not make data available to a pop.
- Simultaneous push and pop:
  - Both accepted: both pointers advance, `count` unchanged.
  - When full: pop only is accepted.
  - When empty: push only is accepted.
- Wrap-around: address low bits roll from `DEPTH-1` to 0 and the wrap bit toggles. No special casing is required.
- Rejected requests have no side effects: no pointer change, no RAM access.

## Timing
- Reset (`rst`=1 at an edge):
  - Registered outputs: pointers 0, so `w_addr`=0 and `r_addr`=0; `rd_valid`=0; `ovf`=0; `udf`=0.
  - Derived status: `count`=0, `empty`=1, `full`=0.
- During reset: `we` and `re` are forced to 0 combinationally in every cycle `rst` is high, so the RAM is neither written nor read.
- RAM contents are not cleared by reset.
- Reset priority: `rst` overrides `push`/`pop`, including mid-burst. Any pending `rd_valid` is cleared on the next edge.
- Write latency: a word pushed at edge N is poppable at edge N+1 (`empty` deasserts after edge N).
- Read latency: with `re`=1 at edge N, RAM `dout` and `rd_valid`=1 are valid in the cycle after edge N. `rd_valid` is `re` delayed by exactly one cycle.
- Status timing: `full`, `empty` and `count` reflect the state after the last edge. No look-ahead.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `ovf` ports are present. `ovf` sets on any edge with `push & full & ~rst`.
  - `udf` ports are present. `udf` sets on any edge with `pop & empty & ~rst`.
  - Both flags hold until `rst`.
- `FIFO_CTRL_ERR_EN` undefined:
  - `ovf` and `udf` ports and their logic are absent.
  - Rejected requests are silently dropped.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `push`=`pop`=1 -> `we`=0, `re`=0, `empty`=1, `count`=0, `w_addr`=0, `r_addr`=0, `rd_valid`=0.
- Fill: push 16 words 0x10..0x1F -> `w_addr` steps 0..15, `count`=16, `full`=1. A 17th push -> `we`=0, `count` stays 16; `ovf`=1 when `FIFO_CTRL_ERR_EN` is defined.
- Drain: pop 16 times -> `r_addr` steps 0..15; `rd_valid`=1 one cycle after each pop, with `dout`=0x10..0x1F in order; then `empty`=1. A 17th pop -> `re`=0, `rd_valid`=0 next cycle; `udf`=1 when `FIFO_CTRL_ERR_EN` is defined.
- Wrap: push 10, pop 10, push 10 -> second-burst `w_addr` runs 10..15 then 0..3, `count`=10; draining returns the second burst in order.
- Simultaneous push and pop:
  - At `count`=5: `count` stays 5 and both addresses advance.
  - At `count`=16: only `re`=1, `count`→15.
  - At `count`=0: only `we`=1, `count`→1.
- Mid-operation reset: at `count`=7, assert `rst` with `pop`=1 -> `re`=0 that cycle, `rd_valid`=0 next cycle, `count`=0, `empty`=1; a following push writes to `w_addr`=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
//==============================================================================
// Module   : fifo_ctrl
// Purpose  : Push/pop controller for a 2**ADDR_W x 8 dual-port RAM FIFO.
//            Optional sticky ovf/udf flags when FIFO_CTRL_ERR_EN is defined.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module fifo_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic              we,
  output logic [ADDR_W-1:0] w_addr,
  output logic              re,
  output logic [ADDR_W-1:0] r_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_rd_valid;
  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  // The extra wrap bit lets a plain subtraction distinguish full from empty.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == DEPTH);
  assign w_empty   = (w_count == '0);
  assign w_push_ok = push & ~w_full & ~rst;
  assign w_pop_ok  = pop & ~w_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_rd_valid <= w_pop_ok;
    end
  end

  assign we       = w_push_ok;
  assign re       = w_pop_ok;
  assign w_addr   = r_wr_ptr[ADDR_W-1:0];
  assign r_addr   = r_rd_ptr[ADDR_W-1:0];
  assign rd_valid = r_rd_valid;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = w_count;

`ifdef FIFO_CTRL_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Flags record requests that were dropped; they only clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (push & w_full) r_ovf <= 1'b1;
      if (pop & w_empty) r_udf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
//==============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Self-checking bench for fifo_ctrl with a behavioural RAM and a
//            queue-based FIFO reference model (FIFO_CTRL_ERR_EN aware).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       we;
  logic [3:0] w_addr;
  logic       re;
  logic [3:0] r_addr;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] din;
  logic [7:0] dout;
`ifdef FIFO_CTRL_ERR_EN
  logic       ovf;
  logic       udf;
`endif

  int n_vec = 0;
  int n_err = 0;

  fifo_ctrl #(.ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .we       (we),
    .w_addr   (w_addr),
    .re       (re),
    .r_addr   (r_addr),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .ovf      (ovf),
    .udf      (udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16x8 dual-port RAM sitting downstream of the controller.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (we) ram[w_addr] <= din;
    if (re) dout <= ram[r_addr];
  end

  // Reference model: FIFO contents as a queue plus accepted-op tallies.
  logic [7:0] mq [$];
  int         wn;
  int         rn;
  bit         m_rv;
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wn    = 0;
    rn    = 0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // One clock cycle: drive, check pre-edge view, clock, update model, check post-edge.
  task automatic cycle(input logic p, input logic o, input logic r, input logic [7:0] d);
    bit exp_we;
    bit exp_re;
    bit was_full;
    bit was_empty;
    push = p;
    pop  = o;
    rst  = r;
    din  = d;
    #1;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    exp_we = p && !r && !was_full;
    exp_re = o && !r && !was_empty;
    check("we",     32'(we),     32'(exp_we));
    check("re",     32'(re),     32'(exp_re));
    check("count",  32'(count),  32'(mq.size()));
    check("full",   32'(full),   32'(was_full));
    check("empty",  32'(empty),  32'(was_empty));
    check("w_addr", 32'(w_addr), 32'(wn % 16));
    check("r_addr", 32'(r_addr), 32'(rn % 16));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (p && was_full)  m_ovf = 1'b1;
      if (o && was_empty) m_udf = 1'b1;
      if (exp_re) begin
        m_dout = mq.pop_front();
        rn++;
      end
      if (exp_we) begin
        mq.push_back(d);
        wn++;
      end
      m_rv = exp_re;
    end
    #1;
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv) check("dout", 32'(dout), 32'(m_dout));
`ifdef FIFO_CTRL_ERR_EN
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  initial begin
    bit bias;
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    din  = 8'h00;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with both requests asserted.
    cycle(1'b1, 1'b1, 1'b1, 8'hAA);
    cycle(1'b1, 1'b1, 1'b1, 8'hAB);

    // Fill 0x10..0x1F, then overflow attempt.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    cycle(1'b1, 1'b0, 1'b0, 8'hEE);

    // Drain, then underflow attempt and an idle cycle.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // Wrap: push 10, pop 10, push 10, drain 10.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Simultaneous push/pop at count 0, 5 and 16.
    cycle(1'b1, 1'b1, 1'b0, 8'h50);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h51 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Mid-operation reset at count 7 with pop requested, then a push.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h87);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h99);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic with phase-biased fill/drain and rare resets.
    bias = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) bias = ~bias;
      cycle(($urandom_range(0, 3) != 0) == bias,
            ($urandom_range(0, 3) != 0) != bias,
            ($urandom_range(0, 99) == 0),
            8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
